// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one tick-based 8N1 UART transmitter among N_REQ byte sources,
// with optional lock bursts. Define ARB_TIMEOUT_EN to add a WAIT watchdog that pulses err.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int D_BIT       = 8,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*D_BIT-1:0]     req_data,
    input  logic [N_REQ-1:0]           lock,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       tx_start,
    output logic [D_BIT-1:0]           tx_din,
    input  logic                       tx_done,
    output logic                       busy,
    output logic                       err
);

    localparam int OW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             txStart_q, txStart_d;
    logic [D_BIT-1:0] txDin_q, txDin_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    burstCnt_q, burstCnt_d;
    logic             busy_q, busy_d;
    logic [OW-1:0]    winner;
    logic             doneValid;
    logic             reload;
    logic             timeoutHit;

    function automatic logic [OW-1:0] rrIndex(input logic [OW-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % N_REQ;
        return sum[OW-1:0];
    endfunction

    // Scanning farthest-first lets the nearest requester after the owner overwrite the others.
    always_comb begin
        winner = owner_q;
        for (int off = N_REQ; off >= 1; off--) begin
            if (req[rrIndex(owner_q, off)]) begin
                winner = rrIndex(owner_q, off);
            end
        end
    end

    // A done pulse coinciding with our own start pulse belongs to no frame of ours.
    assign doneValid = (state_q == WAIT) && tx_done && !txStart_q;
    assign reload    = doneValid && req[owner_q] && lock[owner_q] &&
                       (burstCnt_q < BW'(MAX_BURST));

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] toCnt_q, toCnt_d;
    logic          err_q, err_d;

    assign timeoutHit = (state_q == WAIT) && !doneValid && (toCnt_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        err_d = timeoutHit;
        if (txStart_d) begin
            toCnt_d = '0;
        end else if ((state_q == WAIT) && !timeoutHit) begin
            toCnt_d = toCnt_q + 1'b1;
        end else begin
            toCnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toCnt_q <= '0;
            err_q   <= 1'b0;
        end else begin
            toCnt_q <= toCnt_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeoutHit = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            txStart_q  <= 1'b0;
            txDin_q    <= '0;
            owner_q    <= OW'(N_REQ - 1);
            burstCnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            txStart_q  <= txStart_d;
            txDin_q    <= txDin_d;
            owner_q    <= owner_d;
            burstCnt_q <= burstCnt_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = WAIT;
            WAIT:    if ((doneValid && !reload) || timeoutHit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // owner is left alone on release so it doubles as the round-robin pointer.
    always_comb begin
        grant_d    = '0;
        txStart_d  = 1'b0;
        txDin_d    = txDin_q;
        owner_d    = owner_q;
        burstCnt_d = burstCnt_q;
        busy_d     = (state_d == WAIT);
        if ((state_q == IDLE) && (|req)) begin
            grant_d[winner] = 1'b1;
            txStart_d       = 1'b1;
            txDin_d         = req_data[winner*D_BIT +: D_BIT];
            owner_d         = winner;
            burstCnt_d      = BW'(1);
        end else if (reload) begin
            grant_d[owner_q] = 1'b1;
            txStart_d        = 1'b1;
            txDin_d          = req_data[owner_q*D_BIT +: D_BIT];
            burstCnt_d       = burstCnt_q + 1'b1;
        end
    end

    assign grant    = grant_q;
    assign owner    = owner_q;
    assign tx_start = txStart_q;
    assign tx_din   = txDin_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter, checked each cycle against a
// rule-level arbitration model plus a simple transmitter stand-in.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DB    = 8;
    localparam int MB    = 4;
    localparam int TO    = 64;
    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DB-1:0] reqData;
    logic [N-1:0]    lock;
    logic [N-1:0]    grant;
    logic [1:0]      owner;
    logic            txStart;
    logic [DB-1:0]   txDin;
    logic            txDone;
    logic            busy;
    logic            err;

    uart_tx_arbiter #(
        .N_REQ(N), .D_BIT(DB), .MAX_BURST(MB), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(reqData), .lock(lock),
        .grant(grant), .owner(owner), .tx_start(txStart), .tx_din(txDin),
        .tx_done(txDone), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    logic [DB-1:0] laneMem [N][DEPTH];
    int            head [N];
    int            tail [N];
    bit            laneLock [N];

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: who owns the transmitter, how long it has waited, what it was sent.
    bit            mBusy;
    int            mOwner;
    int            mBurst;
    bit            mStartPrev;
    logic [DB-1:0] mDin;
    int            mAge;

    int            doneCnt;
    bit            autoTx;
    bit            spurAtStart;
    int            errSeen;
    int            grantLane [$];
    logic [DB-1:0] grantByte [$];
    int            pushCount;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic driveInputs();
        for (int i = 0; i < N; i++) begin
            req[i]             = head[i] < tail[i];
            reqData[i*DB +: DB] = (head[i] < tail[i]) ? laneMem[i][head[i]] : '0;
            lock[i]            = laneLock[i];
        end
    endtask

    task automatic applyStimulus(input int lane, input logic [DB-1:0] b);
        if (tail[lane] < DEPTH) begin
            laneMem[lane][tail[lane]] = b;
            tail[lane]++;
            pushCount++;
        end
        driveInputs();
    endtask

    task automatic clearLanes();
        for (int i = 0; i < N; i++) begin
            head[i]     = 0;
            tail[i]     = 0;
            laneLock[i] = 1'b0;
        end
        grantLane.delete();
        grantByte.delete();
        pushCount = 0;
        errSeen   = 0;
    endtask

    task automatic modelReset();
        mBusy       = 1'b0;
        mOwner      = N - 1;
        mBurst      = 0;
        mStartPrev  = 1'b0;
        mDin        = '0;
        mAge        = 0;
        doneCnt     = 0;
        txDone      = 1'b0;
        spurAtStart = 1'b0;
    endtask

    task automatic assertReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_tx_start", txStart, 0);
        checkOutput("rst_tx_din", txDin, 0);
        checkOutput("rst_owner", owner, N - 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        clearLanes();
        modelReset();
        driveInputs();
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic stepCycle();
        logic [N-1:0]    sReq, sLock, expGrant;
        logic [N*DB-1:0] sData;
        logic            sDone, expStart, expErr, validDone;
        int              w;
        sReq  = req;
        sLock = lock;
        sDone = txDone;
        sData = reqData;
        expGrant  = '0;
        expStart  = 1'b0;
        expErr    = 1'b0;
        validDone = mBusy && sDone && !mStartPrev;
        if (!mBusy) begin
            if (sReq != 0) begin
                w = -1;
                for (int off = 1; off <= N; off++) begin
                    if (w < 0 && sReq[(mOwner + off) % N]) w = (mOwner + off) % N;
                end
                mOwner      = w;
                mBurst      = 1;
                expGrant[w] = 1'b1;
                expStart    = 1'b1;
                mDin        = sData[w*DB +: DB];
                mBusy       = 1'b1;
                mAge        = 0;
            end
        end else if (validDone) begin
            if (sReq[mOwner] && sLock[mOwner] && mBurst < MB) begin
                mBurst++;
                expGrant[mOwner] = 1'b1;
                expStart         = 1'b1;
                mDin             = sData[mOwner*DB +: DB];
                mAge             = 0;
            end else begin
                mBusy = 1'b0;
            end
        end else begin
            mAge++;
`ifdef ARB_TIMEOUT_EN
            if (mAge == TO) begin
                expErr = 1'b1;
                mBusy  = 1'b0;
            end
`endif
        end
        mStartPrev = expStart;

        @(posedge clk);
        #1;
        checkOutput("grant", grant, expGrant);
        checkOutput("tx_start", txStart, expStart);
        checkOutput("tx_din", txDin, mDin);
        checkOutput("owner", owner, mOwner);
        checkOutput("busy", busy, mBusy);
        checkOutput("err", err, expErr);

        if (err) errSeen++;
        for (int i = 0; i < N; i++) begin
            if (grant[i] && head[i] < tail[i]) begin
                grantLane.push_back(i);
                grantByte.push_back(laneMem[i][head[i]]);
                head[i]++;
            end
        end
        txDone = 1'b0;
        if (autoTx) begin
            if (doneCnt > 0) begin
                doneCnt--;
                if (doneCnt == 0) txDone = 1'b1;
            end
            if (txStart) begin
                doneCnt = 1 + $urandom_range(1, 4);
                if (spurAtStart) begin
                    txDone      = 1'b1;
                    spurAtStart = 1'b0;
                end
            end
        end
        driveInputs();
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) stepCycle();
    endtask

    function automatic int laneAt(input int k);
        return (k < grantLane.size()) ? grantLane[k] : -1;
    endfunction

    function automatic logic [DB-1:0] byteAt(input int k);
        return (k < grantByte.size()) ? grantByte[k] : 8'hxx;
    endfunction

    initial begin
        int pending;
        int expOrder [5];
        rst    = 1'b1;
        txDone = 1'b0;
        autoTx = 1'b1;
        req    = '0;
        lock   = '0;
        reqData = '0;
        clearLanes();
        modelReset();

        // Single request straight out of reset.
        assertReset();
        releaseReset();
        applyStimulus(0, 8'hA5);
        runCycles(15);
        checkOutput("single_lane", laneAt(0), 0);
        checkOutput("single_byte", byteAt(0), 8'hA5);

        // Everybody requesting: rotation 0,1,2,3,0.
        assertReset();
        releaseReset();
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, 8'h40 + 8'(i));
            applyStimulus(i, 8'h50 + 8'(i));
        end
        runCycles(70);
        expOrder = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) checkOutput("rr_order", laneAt(k), expOrder[k]);
        checkOutput("rr_byte0", byteAt(0), 8'h40);
        checkOutput("rr_byte3", byteAt(3), 8'h43);
        checkOutput("rr_byte4", byteAt(4), 8'h50);

        // Locked burst of three, then the waiting requester.
        assertReset();
        releaseReset();
        laneLock[2] = 1'b1;
        applyStimulus(2, 8'h11);
        applyStimulus(2, 8'h22);
        applyStimulus(2, 8'h33);
        stepCycle();
        applyStimulus(0, 8'h77);
        runCycles(40);
        checkOutput("lock_l0", laneAt(0), 2);
        checkOutput("lock_l2", laneAt(2), 2);
        checkOutput("lock_b1", byteAt(1), 8'h22);
        checkOutput("lock_b2", byteAt(2), 8'h33);
        checkOutput("lock_next", laneAt(3), 0);
        checkOutput("lock_next_b", byteAt(3), 8'h77);

        // Burst cap forces release after MB bytes.
        assertReset();
        releaseReset();
        laneLock[1] = 1'b1;
        for (int k = 0; k < 10; k++) applyStimulus(1, 8'h10 + 8'(k));
        stepCycle();
        applyStimulus(3, 8'hC3);
        runCycles(120);
        for (int k = 0; k < MB; k++) checkOutput("cap_lane", laneAt(k), 1);
        checkOutput("cap_other", laneAt(MB), 3);
        checkOutput("cap_other_b", byteAt(MB), 8'hC3);
        checkOutput("cap_back", laneAt(MB + 1), 1);
        checkOutput("cap_back_b", byteAt(MB + 1), 8'h14);

        // Spurious done in IDLE and during the start cycle.
        assertReset();
        releaseReset();
        txDone = 1'b1;
        stepCycle();
        spurAtStart = 1'b1;
        applyStimulus(3, 8'h3C);
        runCycles(20);
        checkOutput("spur_grants", grantLane.size(), 1);
        checkOutput("spur_byte", byteAt(0), 8'h3C);

        // Randomized traffic with random locks and stray done pulses.
        assertReset();
        releaseReset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 63) == 0) applyStimulus(i, 8'($urandom));
                if ((c % 16) == 0) laneLock[i] = 1'($urandom);
            end
            if (doneCnt == 0 && !txStart && $urandom_range(0, 29) == 0) txDone = 1'b1;
            driveInputs();
            stepCycle();
        end
        runCycles(300);
        pending = 0;
        for (int i = 0; i < N; i++) pending += tail[i] - head[i];
        checkOutput("rand_drained", pending, 0);
        checkOutput("rand_count", grantLane.size(), pushCount);

        // Transmitter never answers.
        assertReset();
        releaseReset();
        autoTx = 1'b0;
        applyStimulus(0, 8'hE0);
        applyStimulus(1, 8'hE1);
        runCycles(TO + 10);
`ifdef ARB_TIMEOUT_EN
        checkOutput("to_err_pulses", errSeen, 1);
        checkOutput("to_next_lane", laneAt(1), 1);
`else
        checkOutput("to_busy_held", busy, 1);
        checkOutput("to_no_err", errSeen, 0);
        checkOutput("to_grants", grantLane.size(), 1);
`endif
        autoTx = 1'b1;

        // Asynchronous reset mid-frame; nothing granted while held.
        assertReset();
        releaseReset();
        autoTx = 1'b0;
        applyStimulus(2, 8'h5A);
        runCycles(3);
        assertReset();
        applyStimulus(1, 8'h99);
        @(posedge clk);
        #1;
        checkOutput("grant_in_reset", grant, 0);
        checkOutput("busy_in_reset", busy, 0);
        autoTx = 1'b1;
        releaseReset();
        runCycles(15);
        checkOutput("post_rst_lane", laneAt(0), 1);
        checkOutput("post_rst_byte", byteAt(0), 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1, tick-based, same family as the UART receiver) among N_REQ byte requesters, using round-robin arbitration.
- Sequences the transmitter: loads tx_din, pulses tx_start, then waits for tx_done before granting again.
- Optional packet lock lets one requester send back-to-back bytes, bounded by MAX_BURST.
- Sits between the host-side message sources and the UART transmitter.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- D_BIT, 8, data bits per frame; matches transmitter D_bit.
- MAX_BURST, 16, maximum consecutive bytes per locked grant (1..255).
- TIMEOUT_CYC, 4096, clk cycles allowed in WAIT before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester byte-valid; held until granted.
- req_data  in  N_REQ*D_BIT  byte of requester i at bits [i*D_BIT +: D_BIT].
- lock  in  N_REQ  requester i wants to keep ownership after its current byte.
- grant  out  N_REQ  one-hot, one-cycle pulse; byte of that requester accepted.
- owner  out  $clog2(N_REQ)  index of the current/last owner.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_din  out  D_BIT  byte to the transmitter; stable from tx_start until the next load.
- tx_done  in  1  one-cycle frame-complete pulse from the transmitter.
- busy  out  1  high whenever state != IDLE.
- err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset values: state IDLE, grant 0, tx_start 0, tx_din 0, owner N_REQ-1, burst_cnt 0, busy 0, err 0, timeout counter 0.
- All outputs are registered.
- State machine has two states: IDLE and WAIT.
- IDLE:
  - If req != 0 at clock edge k, pick the winner by searching from (owner+1) mod N_REQ upward with wrap.
  - At edge k: grant <= onehot(winner), tx_start <= 1, tx_din <= req_data[winner], owner <= winner, burst_cnt <= 1, state <= WAIT.
  - Latency: req sampled at edge k, so grant and tx_start are high during cycle k..k+1.
- grant and tx_start are cleared at the next edge unless reloaded.
- The requester must deassert or advance req on the cycle after seeing grant. req seen while grant is still high is not re-granted, because state is WAIT.
- WAIT:
  - tx_done is ignored during the cycle in which tx_start is high. It is sampled from the following cycle onward.
  - On tx_done with req[owner] && lock[owner] && burst_cnt < MAX_BURST: reload immediately (same edge) with grant, tx_start, tx_din = req_data[owner], burst_cnt+1. Stay in WAIT.
  - On tx_done otherwise: state <= IDLE, owner unchanged (it is the round-robin pointer).
  - The earliest new grant after release is the edge after entering IDLE, giving a one-cycle gap.
- Fairness:
  - After release, the old owner has lowest priority.
  - A burst that reaches MAX_BURST forces a release even if lock is still high.
  - If the same requester is the only one requesting, it may win again from IDLE.
- req[i] without a grant is never dropped. Requests from non-owners during WAIT are simply pending.
- tx_done in IDLE is ignored.
- lock without req has no effect.
- lock is sampled only at the tx_done edge.
- Async rst mid-frame: arbiter returns to IDLE immediately and the transmitter is reset by the same rst. No grant is issued during reset.
- busy = (state == WAIT).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - WAIT counter starts at 0 on each tx_start and increments every cycle.
  - If it reaches TIMEOUT_CYC-1 without tx_done: err pulses for 1 cycle, state <= IDLE, burst is released, and owner keeps the failed index, so it gets lowest priority next.
  - A tx_done arriving on that same edge wins: no err.
- Undefined: no counter logic; err is tied to 0; WAIT waits indefinitely for tx_done.

Test Plan:
- Single request: req=4'b0001, data 8'hA5 after reset. Expect grant=0001 and tx_start=1 in the same cycle, and tx_din=A5. After tx_done, busy drops one cycle later.
- All requesting: req=4'b1111 held, refilled after each grant. Expect grant order 0,1,2,3,0 and tx_din matching each lane's byte.
- Locked burst: requester 2 has lock=1 and 3 bytes 11,22,33; requester 0 also requests. Expect 11,22,33 back-to-back (grant on each tx_done edge), then requester 0 granted after the one-cycle IDLE gap.
- Burst cap: MAX_BURST=4, requester 1 lock held with 10 bytes pending and requester 3 pending. Expect 4 bytes from requester 1, then requester 3, then requester 1 again.
- Spurious/edge done: tx_done asserted in IDLE and in the tx_start cycle. Expect no state change or grant; the next real tx_done completes the frame.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYC=64): tx_done never arrives. Expect err pulse 64 cycles after tx_start, then IDLE and the next requester granted. Without the macro: busy stays 1 and err stays 0.
